// File: rtl/lcd_timing_monitor.sv
// Pixel-bus timing monitor: measures line/frame geometry from DE/HSYNC/VSYNC,
// declares lock on repeated identical frames and captures one probed pixel.
module lcd_timing_monitor #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2,
    parameter int HS_ACT_LOW  = 1,
    parameter int VS_ACT_LOW  = 1
) (
    input  logic          PixelClk,
    input  logic          nRST,
    input  logic          LCD_DE,
    input  logic          LCD_HSYNC,
    input  logic          LCD_VSYNC,
    input  logic [4:0]    LCD_R,
    input  logic [5:0]    LCD_G,
    input  logic [4:0]    LCD_B,
    input  logic [CW-1:0] probe_x,
    input  logic [CW-1:0] probe_y,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_start,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic          frame_done,
    output logic          locked,
    output logic [15:0]   probe_pix,
    output logic          probe_stb,
    output logic          err_timeout
);

    typedef enum logic {SEEK, MEASURE} state_t;

    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] MAXV = '1;

    state_t        state, state_n;
    logic          de_r, hs_r, vs_r, hs_d, vs_d;
    logic [15:0]   rgb_r;
    logic          hs_edge, vs_edge;

    // hcnt_q holds the in-line position of the current cycle; the edge cycle itself is position 0
    logic [CW-1:0] hcnt_q, lcnt, ycnt, de_cnt, first_off;
    logic          line_valid;
    logic [CW-1:0] ht_c, hst_c, ha_c;
    logic          have_ht, have_h, frame_bad;
    logic [CW-1:0] px_q, py_q;
    logic          probe_done;
    logic [3:0]    match_cnt;
    logic          lock_q;

    logic [CW-1:0] ht_n, hst_n, ha_n, vt_n, va_n;
    logic          have_ht_n, have_h_n, bad_n, same;
    logic [3:0]    match_n;
    logic [CW-1:0] cur_x, cur_y, sel_px, sel_py;
    logic          hit, to_hit;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_r  <= 1'b0;
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_r <= '0;
        end else begin
            de_r  <= LCD_DE;
            hs_r  <= (HS_ACT_LOW != 0) ? ~LCD_HSYNC : LCD_HSYNC;
            vs_r  <= (VS_ACT_LOW != 0) ? ~LCD_VSYNC : LCD_VSYNC;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            rgb_r <= {LCD_R, LCD_G, LCD_B};
        end
    end

    assign hs_edge = hs_r & ~hs_d;
    assign vs_edge = vs_r & ~vs_d;

    // Fires in the cycle a counter is about to reach all-ones, so the pulse is single
    assign to_hit = (!hs_edge && hcnt_q == MAXV - ONE) ||
                    (hs_edge && !vs_edge && lcnt == MAXV - ONE);

    always_comb begin
        state_n = state;
        if (to_hit)
            state_n = SEEK;
        else if (vs_edge)
            state_n = MEASURE;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) state <= SEEK;
        else       state <= state_n;
    end

    // Close out the line ending this cycle (if any) before any frame-end publish
    always_comb begin
        ht_n      = ht_c;
        hst_n     = hst_c;
        ha_n      = ha_c;
        have_ht_n = have_ht;
        have_h_n  = have_h;
        bad_n     = frame_bad;
        if (hs_edge && line_valid && state == MEASURE) begin
            if (!have_ht) begin
                ht_n      = hcnt_q;
                have_ht_n = 1'b1;
            end else if (hcnt_q != ht_c) begin
                bad_n = 1'b1;
            end
            if (de_cnt != '0) begin
                if (!have_h) begin
                    hst_n    = first_off;
                    ha_n     = de_cnt;
                    have_h_n = 1'b1;
                end else if (first_off != hst_c || de_cnt != ha_c) begin
                    bad_n = 1'b1;
                end
            end
        end
        vt_n = lcnt + (hs_edge ? ONE : '0);
        va_n = ycnt + ((hs_edge && de_cnt != '0) ? ONE : '0);
        same = !bad_n && ht_n == h_total && hst_n == h_start && ha_n == h_active &&
               vt_n == v_total && va_n == v_active;
        if (!same)
            match_n = 4'd0;
        else if (match_cnt == 4'hF)
            match_n = match_cnt;
        else
            match_n = match_cnt + 4'd1;
    end

    // Coordinates of the current cycle, with a DE coincident to an hs edge starting a new line
    always_comb begin
        cur_x  = hs_edge ? '0 : de_cnt;
        cur_y  = ycnt;
        if (vs_edge)
            cur_y = '0;
        else if (hs_edge && de_cnt != '0)
            cur_y = ycnt + ONE;
        sel_px = vs_edge ? probe_x : px_q;
        sel_py = vs_edge ? probe_y : py_q;
        hit    = de_r && (state == MEASURE || vs_edge) && (vs_edge || !probe_done) &&
                 cur_x == sel_px && cur_y == sel_py;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            hcnt_q      <= '0;
            lcnt        <= '0;
            ycnt        <= '0;
            de_cnt      <= '0;
            first_off   <= '0;
            line_valid  <= 1'b0;
            ht_c        <= '0;
            hst_c       <= '0;
            ha_c        <= '0;
            have_ht     <= 1'b0;
            have_h      <= 1'b0;
            frame_bad   <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            probe_done  <= 1'b0;
            match_cnt   <= 4'd0;
            lock_q      <= 1'b0;
            h_total     <= '0;
            h_start     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            frame_done  <= 1'b0;
            probe_pix   <= '0;
            probe_stb   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            probe_stb   <= 1'b0;
            err_timeout <= 1'b0;

            if (hs_edge) begin
                hcnt_q     <= ONE;
                lcnt       <= (lcnt == MAXV) ? lcnt : lcnt + ONE;
                ycnt       <= ycnt + ((de_cnt != '0) ? ONE : '0);
                de_cnt     <= de_r ? ONE : '0;
                line_valid <= 1'b1;
            end else begin
                hcnt_q <= (hcnt_q == MAXV) ? hcnt_q : hcnt_q + ONE;
                if (de_r && de_cnt != MAXV)
                    de_cnt <= de_cnt + ONE;
            end
            if (de_r && (hs_edge || de_cnt == '0))
                first_off <= hs_edge ? '0 : hcnt_q;

            ht_c      <= ht_n;
            hst_c     <= hst_n;
            ha_c      <= ha_n;
            have_ht   <= have_ht_n;
            have_h    <= have_h_n;
            frame_bad <= bad_n;

            if (hit) begin
                probe_pix  <= rgb_r;
                probe_stb  <= 1'b1;
                probe_done <= 1'b1;
            end

            if (vs_edge) begin
                lcnt       <= '0;
                ycnt       <= '0;
                line_valid <= hs_edge;
                px_q       <= probe_x;
                py_q       <= probe_y;
                probe_done <= hit;
                ht_c       <= '0;
                hst_c      <= '0;
                ha_c       <= '0;
                have_ht    <= 1'b0;
                have_h     <= 1'b0;
                frame_bad  <= 1'b0;
            end

            if (to_hit) begin
                err_timeout <= 1'b1;
                lock_q      <= 1'b0;
                match_cnt   <= 4'd0;
            end else if (vs_edge && state == MEASURE) begin
                h_total    <= ht_n;
                h_start    <= hst_n;
                h_active   <= ha_n;
                v_total    <= vt_n;
                v_active   <= va_n;
                frame_done <= 1'b1;
                match_cnt  <= match_n;
                lock_q     <= (match_n >= 4'(LOCK_FRAMES - 1)) && !bad_n;
            end
        end
    end

    // A bad line seen mid-frame drops lock immediately rather than waiting for publish
    assign locked = lock_q && !frame_bad;

endmodule
